// File: rtl/fp16_pkg.sv
// Shared FP16 definitions for the sequential multiplier and its sibling
// FP ALU blocks: field layout, constants, FSM states and flag positions.
package fp16_pkg;

    localparam int EXP_W     = 5;
    localparam int FRAC_W    = 10;
    localparam int BIAS      = 15;
    localparam int EXP_MAX   = 31;
    localparam int SIG_W     = FRAC_W + 1;   // significand with hidden one
    localparam int PROD_W    = 2 * SIG_W;    // full significand product
    localparam int EXP_INT_W = 7;            // signed working exponent

    localparam logic [15:0] QNAN = 16'h7FFF;

    localparam int FLAG_W         = 3;
    localparam int FLAG_INVALID   = 2;
    localparam int FLAG_OVERFLOW  = 1;
    localparam int FLAG_UNDERFLOW = 0;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp16_t;

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        NORM,
        DONE
    } state_t;

endpackage

// File: rtl/fp16_classify.sv
// Combinational FP16 operand classifier (zero / inf / NaN); denormals are
// reported as zero so downstream datapaths can flush them.
module fp16_classify
    import fp16_pkg::*;
(
    input  logic [EXP_W-1:0]  exp_field,
    input  logic [FRAC_W-1:0] frac_field,
    output logic              is_zero,
    output logic              is_inf,
    output logic              is_nan
);

    logic exp_all_ones;

    assign exp_all_ones = &exp_field;
    assign is_zero      = (exp_field == '0);
    assign is_inf       = exp_all_ones && (frac_field == '0);
    assign is_nan       = exp_all_ones && (frac_field != '0);

endmodule

// File: rtl/fp16_mul_seq.sv
// Sequential FP16 multiplier: radix-2 shift-add significand product, one bit
// per cycle, valid/ready on both sides. Define FP16_MUL_RNE_EN for RNE rounding.
module fp16_mul_seq
    import fp16_pkg::*;
#(
    parameter logic [15:0] QNAN_VALUE = QNAN,
    parameter int          CNT_W      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       a,
    input  logic [15:0]       b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out,
    output logic [FLAG_W-1:0] flags
);

    localparam logic [CNT_W-1:0]            LAST_CNT = CNT_W'(SIG_W - 1);
    localparam logic signed [EXP_INT_W-1:0] EXP_OVF  = EXP_INT_W'(EXP_MAX);
    localparam logic signed [EXP_INT_W-1:0] EXP_BIAS = EXP_INT_W'(BIAS);
    localparam logic signed [EXP_INT_W-1:0] EXP_ONE  = EXP_INT_W'(1);
    localparam logic signed [EXP_INT_W-1:0] EXP_ZERO = '0;

    state_t state, state_next;

    fp16_t op_a, op_b;
    logic  zero_a, inf_a, nan_a;
    logic  zero_b, inf_b, nan_b;
    logic  accept, res_sign, special;
    logic [15:0]       special_out;
    logic [FLAG_W-1:0] special_flags;

    logic                        sign_r;
    logic [SIG_W-1:0]            ma, mb;
    logic [PROD_W-1:0]           acc;
    logic [CNT_W-1:0]            cnt;
    logic signed [EXP_INT_W-1:0] exp_r;

    logic [FRAC_W-1:0]           frac_t, frac_f;
    logic signed [EXP_INT_W-1:0] exp_n, exp_f;
    logic [15:0]                 norm_out;
    logic [FLAG_W-1:0]           norm_flags;
`ifdef FP16_MUL_RNE_EN
    logic             guard, sticky;
    logic [SIG_W:0]   sig_rnd;
`endif

    assign op_a = a;
    assign op_b = b;

    fp16_classify u_class_a (
        .exp_field  (op_a.exp),
        .frac_field (op_a.frac),
        .is_zero    (zero_a),
        .is_inf     (inf_a),
        .is_nan     (nan_a)
    );

    fp16_classify u_class_b (
        .exp_field  (op_b.exp),
        .frac_field (op_b.frac),
        .is_zero    (zero_b),
        .is_inf     (inf_b),
        .is_nan     (nan_b)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign res_sign  = op_a.sign ^ op_b.sign;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        special       = zero_a | zero_b | inf_a | inf_b | nan_a | nan_b;
        special_out   = {res_sign, {(EXP_W + FRAC_W){1'b0}}};
        special_flags = '0;
        if (nan_a || nan_b || (inf_a && zero_b) || (zero_a && inf_b)) begin
            special_out                 = QNAN_VALUE;
            special_flags[FLAG_INVALID] = 1'b1;
        end else if (inf_a || inf_b) begin
            special_out = {res_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = special ? DONE : MULT;
            MULT:    if (cnt == LAST_CNT) state_next = NORM;
            NORM:    state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Product in [1,4): the top bit selects which 10-bit window is the fraction.
    always_comb begin
        frac_t     = acc[PROD_W-3 -: FRAC_W];
        exp_n      = exp_r;
        if (acc[PROD_W-1]) begin
            frac_t = acc[PROD_W-2 -: FRAC_W];
            exp_n  = exp_r + EXP_ONE;
        end
`ifdef FP16_MUL_RNE_EN
        guard   = acc[PROD_W-1] ? acc[SIG_W-1] : acc[SIG_W-2];
        sticky  = acc[PROD_W-1] ? |acc[SIG_W-2:0] : |acc[SIG_W-3:0];
        sig_rnd = {2'b01, frac_t} + {{SIG_W{1'b0}}, guard & (sticky | frac_t[0])};
        if (sig_rnd[SIG_W]) begin
            frac_f = sig_rnd[FRAC_W:1];
            exp_f  = exp_n + EXP_ONE;
        end else begin
            frac_f = sig_rnd[FRAC_W-1:0];
            exp_f  = exp_n;
        end
`else
        frac_f = frac_t;
        exp_f  = exp_n;
`endif
        norm_out   = {sign_r, exp_f[EXP_W-1:0], frac_f};
        norm_flags = '0;
        if (exp_f >= EXP_OVF) begin
            norm_out                  = {sign_r, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            norm_flags[FLAG_OVERFLOW] = 1'b1;
        end else if (exp_f <= EXP_ZERO) begin
            norm_out                   = {sign_r, {(EXP_W + FRAC_W){1'b0}}};
            norm_flags[FLAG_UNDERFLOW] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_r <= 1'b0;
            ma     <= '0;
            mb     <= '0;
            acc    <= '0;
            cnt    <= '0;
            exp_r  <= '0;
            out    <= '0;
            flags  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sign_r <= res_sign;
                        ma     <= {1'b1, op_a.frac};
                        mb     <= {1'b1, op_b.frac};
                        acc    <= '0;
                        cnt    <= '0;
                        exp_r  <= $signed({2'b00, op_a.exp}) + $signed({2'b00, op_b.exp}) - EXP_BIAS;
                        if (special) begin
                            out   <= special_out;
                            flags <= special_flags;
                        end
                    end
                end
                MULT: begin
                    if (mb[cnt]) acc <= acc + (PROD_W'(ma) << cnt);
                    cnt <= cnt + CNT_W'(1);
                end
                NORM: begin
                    out   <= norm_out;
                    flags <= norm_flags;
                end
                default: ;
            endcase
        end
    end

endmodule
